// File: rtl/tuner_phy_pkg.sv
// Shared types for the ring tuner PHY stack: sequencer state encoding and
// the request/status flags the sequencer decodes from its next state.
package tuner_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEARCH   = 3'd1,
    ST_SELECT   = 3'd2,
    ST_LOCK_ACQ = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_BACKOFF  = 3'd5,
    ST_FAULT    = 3'd6
  } tuner_seq_state_e;

  typedef struct packed {
    logic search_req;
    logic lock_req;
    logic locked;
    logic err;
  } seq_flags_t;

  // Flag set that is valid while the sequencer sits in state s.
  function automatic seq_flags_t flags_of(input tuner_seq_state_e s);
    seq_flags_t f;
    f = '0;
    case (s)
      ST_SEARCH:   f.search_req = 1'b1;
      ST_LOCK_ACQ: f.lock_req   = 1'b1;
      ST_LOCKED: begin
        f.lock_req = 1'b1;
        f.locked   = 1'b1;
      end
      ST_FAULT:    f.err        = 1'b1;
      default:     ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/tuner_seq_peak_buf.sv
// Peak capture buffer: stores peaks in arrival order, counts them, and flags
// any peak dropped because the buffer was already full.
module tuner_seq_peak_buf #(
  parameter int NUM_TARGET = 8,
  parameter int DATA_W     = 16,
  localparam int IDX_W     = $clog2(NUM_TARGET),
  localparam int CNT_W     = $clog2(NUM_TARGET + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_val,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NUM_TARGET];
  logic              full;

  assign full = (count == CNT_W'(NUM_TARGET));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (wr_val) begin
      if (full) ovf   <= 1'b1;
      else      count <= count + CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read below
  // the valid count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wr_val && !full && !clear) mem[count[IDX_W-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/tuner_seq_ctrl.sv
// Ring tuner sequencer: search, peak selection, lock acquisition and lock
// maintenance with bounded retry and a terminal fault state.
module tuner_seq_ctrl
  import tuner_phy_pkg::*;
#(
  parameter int DAC_WIDTH      = 8,
  parameter int ADC_WIDTH      = 8,
  parameter int NUM_TARGET     = 8,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int BACKOFF_CYCLES = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_en,
  input  logic [$clog2(NUM_TARGET)-1:0]   i_cfg_target_idx,
  output logic                            o_search_req,
  input  logic                            i_peak_val,
  input  logic [ADC_WIDTH-1:0]            i_peak_pwr,
  input  logic [DAC_WIDTH-1:0]            i_peak_tune,
  input  logic                            i_search_done,
  output logic                            o_lock_req,
  output logic [ADC_WIDTH-1:0]            o_lock_pwr_peak,
  output logic [DAC_WIDTH-1:0]            o_lock_tune_peak,
  input  logic                            i_lock_locked,
  input  logic                            i_lock_lost,
  output logic                            o_locked,
  output logic                            o_err,
  output logic                            o_peak_ovf,
  output logic [$clog2(MAX_RETRY+1)-1:0]  o_retry_cnt,
  output tuner_seq_state_e                o_state_mon
);

  localparam int CNT_W   = $clog2(NUM_TARGET + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int PEAK_W  = ADC_WIDTH + DAC_WIDTH;
  localparam int TMAX    = (LOCK_TIMEOUT > BACKOFF_CYCLES) ? LOCK_TIMEOUT : BACKOFF_CYCLES;
  localparam int TIMER_W = $clog2(TMAX + 1);

  tuner_seq_state_e   state, state_next;
  seq_flags_t         flags;
  logic [TIMER_W-1:0] timer;
  logic [RETRY_W-1:0] retry_cnt;

  logic               buf_clear;
  logic               buf_wr;
  logic [CNT_W-1:0]   buf_count;
  logic               buf_ovf;
  logic [PEAK_W-1:0]  buf_rd_data;
  logic               sel_load;
  logic               retry_inc;
  logic               retry_clr;

  assign buf_wr = i_en && (state == ST_SEARCH) && i_peak_val;

  tuner_seq_peak_buf #(
    .NUM_TARGET (NUM_TARGET),
    .DATA_W     (PEAK_W)
  ) u_peak_buf (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clear   (buf_clear),
    .wr_val  (buf_wr),
    .wr_data ({i_peak_pwr, i_peak_tune}),
    .rd_idx  (i_cfg_target_idx),
    .count   (buf_count),
    .ovf     (buf_ovf),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next = state;
    buf_clear  = 1'b0;
    sel_load   = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;

    if (!i_en) begin
      state_next = ST_IDLE;
      buf_clear  = 1'b1;
      retry_clr  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_SEARCH;
          buf_clear  = 1'b1;
        end
        ST_SEARCH: begin
          if (i_search_done) state_next = ST_SELECT;
        end
        ST_SELECT: begin
          if (CNT_W'(i_cfg_target_idx) < buf_count) begin
            state_next = ST_LOCK_ACQ;
            sel_load   = 1'b1;
          end else begin
            retry_inc  = 1'b1;
          end
        end
        ST_LOCK_ACQ: begin
          if (i_lock_locked)                              state_next = ST_LOCKED;
          else if (timer == TIMER_W'(LOCK_TIMEOUT - 1))   retry_inc  = 1'b1;
        end
        ST_LOCKED: begin
          if (i_lock_lost) retry_inc = 1'b1;
        end
        ST_BACKOFF: begin
          if (timer == TIMER_W'(BACKOFF_CYCLES - 1)) begin
            state_next = ST_SEARCH;
            buf_clear  = 1'b1;
          end
        end
        ST_FAULT: state_next = ST_FAULT;
        default:  state_next = ST_IDLE;
      endcase

      // Shared retry path: exhausted retries end in FAULT instead of BACKOFF.
      if (retry_inc) begin
        if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
          state_next = ST_FAULT;
          retry_inc  = 1'b0;
        end else begin
          state_next = ST_BACKOFF;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= ST_IDLE;
      flags            <= '0;
      timer            <= '0;
      retry_cnt        <= '0;
      o_lock_pwr_peak  <= '0;
      o_lock_tune_peak <= '0;
    end else begin
      state <= state_next;
      flags <= flags_of(state_next);

      // Timer runs only in the two timed states and restarts on every entry.
      if (state_next != state)
        timer <= '0;
      else if (state == ST_LOCK_ACQ || state == ST_BACKOFF)
        timer <= timer + TIMER_W'(1);

      if (retry_clr || (state_next == ST_LOCKED && state != ST_LOCKED))
        retry_cnt <= '0;
      else if (retry_inc)
        retry_cnt <= retry_cnt + RETRY_W'(1);

      if (sel_load) {o_lock_pwr_peak, o_lock_tune_peak} <= buf_rd_data;
    end
  end

  assign o_search_req = flags.search_req;
  assign o_lock_req   = flags.lock_req;
  assign o_locked     = flags.locked;
  assign o_err        = flags.err;
  assign o_peak_ovf   = buf_ovf;
  assign o_retry_cnt  = retry_cnt;
  assign o_state_mon  = state;

endmodule

// File: tb/tb_tuner_seq_ctrl.sv
// Self-checking bench for tuner_seq_ctrl: directed scenarios plus randomized
// searches compared against a queue-based model of peak capture and selection.
module tb_tuner_seq_ctrl;
  import tuner_phy_pkg::*;

  localparam int NT = 8;
  localparam int LT = 1024;
  localparam int BC = 16;
  localparam int MR = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [2:0]       idx = '0;
  logic             peak_val = 1'b0;
  logic [7:0]       peak_pwr = '0;
  logic [7:0]       peak_tune = '0;
  logic             search_done = 1'b0;
  logic             lock_locked = 1'b0;
  logic             lock_lost = 1'b0;
  logic             search_req, lock_req, locked, err, peak_ovf;
  logic [7:0]       lock_pwr, lock_tune;
  logic [1:0]       retry_cnt;
  tuner_seq_state_e state_mon;

  int checks = 0;
  int failures = 0;
  logic [7:0] q_pwr[$];
  logic [7:0] q_tune[$];

  tuner_seq_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_en             (en),
    .i_cfg_target_idx (idx),
    .o_search_req     (search_req),
    .i_peak_val       (peak_val),
    .i_peak_pwr       (peak_pwr),
    .i_peak_tune      (peak_tune),
    .i_search_done    (search_done),
    .o_lock_req       (lock_req),
    .o_lock_pwr_peak  (lock_pwr),
    .o_lock_tune_peak (lock_tune),
    .i_lock_locked    (lock_locked),
    .i_lock_lost      (lock_lost),
    .o_locked         (locked),
    .o_err            (err),
    .o_peak_ovf       (peak_ovf),
    .o_retry_cnt      (retry_cnt),
    .o_state_mon      (state_mon)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    en = 0; idx = 0; peak_val = 0; peak_pwr = 0; peak_tune = 0;
    search_done = 0; lock_locked = 0; lock_lost = 0;
    rst_n = 0;
    step(2);
    rst_n = 1;
    step(1);
  endtask

  // mode 0: done after the last peak, 1: done with the last peak, 2: no done.
  task automatic feed_peaks(input int mode, input int gap_max);
    for (int i = 0; i < q_pwr.size(); i++) begin
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gap) begin
        peak_pwr = 8'($urandom); peak_tune = 8'($urandom);
        step();
      end
      peak_val    = 1;
      peak_pwr    = q_pwr[i];
      peak_tune   = q_tune[i];
      search_done = (mode == 1) && (i == q_pwr.size() - 1);
      step();
      peak_val    = 0;
      search_done = 0;
    end
    if (mode == 0 || (mode == 1 && q_pwr.size() == 0)) begin
      search_done = 1;
      step();
      search_done = 0;
    end
  endtask

  task automatic wait_state(input tuner_seq_state_e s, input int budget, output int n);
    n = 0;
    while (state_mon != s && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({search_req, lock_req, locked, err, peak_ovf, lock_pwr, lock_tune, retry_cnt} !== '0) begin
      $display("FAIL reset_outputs got=%h exp=0",
               {search_req, lock_req, locked, err, peak_ovf, lock_pwr, lock_tune, retry_cnt});
      failures++;
    end
    checks++;
    if (state_mon !== ST_IDLE) begin
      $display("FAIL reset_state got=%0d exp=%0d", state_mon, ST_IDLE);
      failures++;
    end
  endtask

  task automatic test_nominal();
    apply_reset();
    idx = 1;
    q_pwr = '{8'd40, 8'd90, 8'd60};
    q_tune = '{8'd10, 8'd20, 8'd30};
    en = 1;
    step();
    checks++;
    if (search_req !== 1'b1 || state_mon !== ST_SEARCH) begin
      $display("FAIL nom_search_rise got req=%b st=%0d exp req=1 st=%0d", search_req, state_mon, ST_SEARCH);
      failures++;
    end
    feed_peaks(0, 0);
    checks++;
    if (state_mon !== ST_SELECT || search_req !== 1'b0) begin
      $display("FAIL nom_select got st=%0d req=%b exp st=%0d req=0", state_mon, search_req, ST_SELECT);
      failures++;
    end
    step();
    checks++;
    if (lock_req !== 1'b1 || lock_pwr !== 8'd90 || lock_tune !== 8'd20) begin
      $display("FAIL nom_peak got req=%b pwr=%0d tune=%0d exp req=1 pwr=90 tune=20", lock_req, lock_pwr, lock_tune);
      failures++;
    end
    step(5);
    lock_locked = 1;
    step();
    checks++;
    if (locked !== 1'b1 || retry_cnt !== 2'd0 || lock_tune !== 8'd20) begin
      $display("FAIL nom_locked got locked=%b retry=%0d tune=%0d exp locked=1 retry=0 tune=20", locked, retry_cnt, lock_tune);
      failures++;
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    idx = 7;
    q_pwr.delete(); q_tune.delete();
    for (int i = 1; i <= 10; i++) begin
      q_pwr.push_back(8'($urandom));
      q_tune.push_back(8'(i));
    end
    en = 1;
    step();
    feed_peaks(1, 0);
    checks++;
    if (peak_ovf !== 1'b1 || state_mon !== ST_SELECT) begin
      $display("FAIL ovf_flag got ovf=%b st=%0d exp ovf=1 st=%0d", peak_ovf, state_mon, ST_SELECT);
      failures++;
    end
    step();
    checks++;
    if (lock_tune !== 8'd8 || lock_pwr !== q_pwr[7]) begin
      $display("FAIL ovf_peak got tune=%0d pwr=%0d exp tune=8 pwr=%0d", lock_tune, lock_pwr, q_pwr[7]);
      failures++;
    end
  endtask

  task automatic test_bad_index();
    int n;
    int backoffs;
    apply_reset();
    idx = 5;
    q_pwr = '{8'd11, 8'd22};
    q_tune = '{8'd33, 8'd44};
    backoffs = 0;
    en = 1;
    step();
    for (int a = 0; a <= MR; a++) begin
      feed_peaks(0, 0);
      step();
      if (a < MR) begin
        checks++;
        if (state_mon !== ST_BACKOFF || retry_cnt !== 2'(a + 1)) begin
          $display("FAIL badidx_retry%0d got st=%0d retry=%0d exp st=%0d retry=%0d",
                   a, state_mon, retry_cnt, ST_BACKOFF, a + 1);
          failures++;
        end
        wait_state(ST_SEARCH, BC + 8, n);
        checks++;
        if (n !== BC || state_mon !== ST_SEARCH) begin
          $display("FAIL badidx_backoff%0d got cycles=%0d st=%0d exp cycles=%0d st=%0d",
                   a, n, state_mon, BC, ST_SEARCH);
          failures++;
        end
        backoffs++;
      end else begin
        checks++;
        if (err !== 1'b1 || retry_cnt !== 2'(MR) || state_mon !== ST_FAULT || backoffs !== MR) begin
          $display("FAIL badidx_fault got err=%b retry=%0d st=%0d backoffs=%0d exp err=1 retry=%0d st=%0d backoffs=%0d",
                   err, retry_cnt, state_mon, backoffs, MR, ST_FAULT, MR);
          failures++;
        end
      end
    end
    step(5);
    checks++;
    if (state_mon !== ST_FAULT || search_req !== 1'b0 || lock_req !== 1'b0) begin
      $display("FAIL badidx_hold got st=%0d sreq=%b lreq=%b exp st=%0d sreq=0 lreq=0",
               state_mon, search_req, lock_req, ST_FAULT);
      failures++;
    end
    en = 0;
    step();
    checks++;
    if (state_mon !== ST_IDLE || err !== 1'b0 || retry_cnt !== 2'd0) begin
      $display("FAIL badidx_clear got st=%0d err=%b retry=%0d exp st=%0d err=0 retry=0",
               state_mon, err, retry_cnt, ST_IDLE);
      failures++;
    end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    idx = 0;
    q_pwr = '{8'd55};
    q_tune = '{8'd77};
    en = 1;
    step();
    feed_peaks(1, 0);
    step();
    n = 0;
    while (lock_req === 1'b1 && n < LT + 16) begin
      n++;
      step();
    end
    checks++;
    if (n !== LT) begin
      $display("FAIL timeout_len got=%0d exp=%0d", n, LT);
      failures++;
    end
    checks++;
    if (state_mon !== ST_BACKOFF || retry_cnt !== 2'd1) begin
      $display("FAIL timeout_retry got st=%0d retry=%0d exp st=%0d retry=1", state_mon, retry_cnt, ST_BACKOFF);
      failures++;
    end
    wait_state(ST_SEARCH, BC + 8, n);
    checks++;
    if (n !== BC || state_mon !== ST_SEARCH) begin
      $display("FAIL timeout_backoff got cycles=%0d st=%0d exp cycles=%0d", n, state_mon, BC);
      failures++;
    end
    // Lock arrives in the very cycle the timeout would fire.
    feed_peaks(1, 0);
    step();
    step(LT - 1);
    lock_locked = 1;
    step();
    checks++;
    if (state_mon !== ST_LOCKED || locked !== 1'b1 || retry_cnt !== 2'd0) begin
      $display("FAIL timeout_race got st=%0d locked=%b retry=%0d exp st=%0d locked=1 retry=0",
               state_mon, locked, retry_cnt, ST_LOCKED);
      failures++;
    end
  endtask

  task automatic test_loss();
    int n;
    lock_lost = 1;
    step();
    lock_lost = 0;
    lock_locked = 0;
    checks++;
    if (locked !== 1'b0 || state_mon !== ST_BACKOFF || retry_cnt !== 2'd1) begin
      $display("FAIL loss_backoff got locked=%b st=%0d retry=%0d exp locked=0 st=%0d retry=1",
               locked, state_mon, retry_cnt, ST_BACKOFF);
      failures++;
    end
    wait_state(ST_SEARCH, BC + 8, n);
    checks++;
    if (state_mon !== ST_SEARCH || search_req !== 1'b1) begin
      $display("FAIL loss_research got st=%0d req=%b exp st=%0d req=1", state_mon, search_req, ST_SEARCH);
      failures++;
    end
    feed_peaks(1, 0);
    step();
    lock_locked = 1;
    step();
    checks++;
    if (locked !== 1'b1 || retry_cnt !== 2'd0 || lock_tune !== 8'd77) begin
      $display("FAIL loss_relock got locked=%b retry=%0d tune=%0d exp locked=1 retry=0 tune=77",
               locked, retry_cnt, lock_tune);
      failures++;
    end
    lock_locked = 0;
  endtask

  task automatic test_abort();
    apply_reset();
    en = 1;
    step();
    q_pwr.delete(); q_tune.delete();
    for (int i = 0; i < 10; i++) begin
      q_pwr.push_back(8'(i)); q_tune.push_back(8'(i));
    end
    feed_peaks(2, 0);
    checks++;
    if (peak_ovf !== 1'b1 || state_mon !== ST_SEARCH) begin
      $display("FAIL abort_pre got ovf=%b st=%0d exp ovf=1 st=%0d", peak_ovf, state_mon, ST_SEARCH);
      failures++;
    end
    en = 0;
    step();
    checks++;
    if (state_mon !== ST_IDLE || search_req !== 1'b0 || peak_ovf !== 1'b0) begin
      $display("FAIL abort_idle got st=%0d req=%b ovf=%b exp st=%0d req=0 ovf=0",
               state_mon, search_req, peak_ovf, ST_IDLE);
      failures++;
    end
    en = 1;
    idx = 0;
    step();
    q_pwr = '{8'd99};
    q_tune = '{8'd88};
    feed_peaks(1, 0);
    step();
    checks++;
    if (lock_req !== 1'b1 || lock_pwr !== 8'd99) begin
      $display("FAIL abort_lockacq got req=%b pwr=%0d exp req=1 pwr=99", lock_req, lock_pwr);
      failures++;
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({search_req, lock_req, locked, err, peak_ovf, lock_pwr, lock_tune, retry_cnt} !== '0 ||
        state_mon !== ST_IDLE) begin
      $display("FAIL abort_async_rst got outs=%h st=%0d exp outs=0 st=%0d",
               {search_req, lock_req, locked, err, peak_ovf, lock_pwr, lock_tune, retry_cnt},
               state_mon, ST_IDLE);
      failures++;
    end
    #1 rst_n = 1;
    step();
    checks++;
    if (state_mon !== ST_SEARCH || search_req !== 1'b1) begin
      $display("FAIL abort_restart got st=%0d req=%b exp st=%0d req=1", state_mon, search_req, ST_SEARCH);
      failures++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int n;
      int cap;
      int tidx;
      int mode;
      bit exp_ovf;
      apply_reset();
      n    = int'($urandom_range(0, 11));
      tidx = int'($urandom_range(0, 7));
      mode = int'($urandom_range(0, 1));
      idx  = 3'(tidx);
      q_pwr.delete(); q_tune.delete();
      for (int i = 0; i < n; i++) begin
        q_pwr.push_back(8'($urandom)); q_tune.push_back(8'($urandom));
      end
      cap     = (n > NT) ? NT : n;
      exp_ovf = (n > NT);
      en = 1;
      step();
      feed_peaks(mode, 3);
      checks++;
      if (peak_ovf !== exp_ovf || state_mon !== ST_SELECT) begin
        $display("FAIL rnd%0d_ovf got ovf=%b st=%0d exp ovf=%b st=%0d (n=%0d)",
                 it, peak_ovf, state_mon, exp_ovf, ST_SELECT, n);
        failures++;
      end
      step();
      checks++;
      if (tidx < cap) begin
        if (lock_req !== 1'b1 || lock_pwr !== q_pwr[tidx] || lock_tune !== q_tune[tidx]) begin
          $display("FAIL rnd%0d_sel got req=%b pwr=%0d tune=%0d exp req=1 pwr=%0d tune=%0d (n=%0d idx=%0d)",
                   it, lock_req, lock_pwr, lock_tune, q_pwr[tidx], q_tune[tidx], n, tidx);
          failures++;
        end
      end else begin
        if (state_mon !== ST_BACKOFF || retry_cnt !== 2'd1 || lock_pwr !== 8'd0 || lock_tune !== 8'd0) begin
          $display("FAIL rnd%0d_noselect got st=%0d retry=%0d pwr=%0d tune=%0d exp st=%0d retry=1 pwr=0 tune=0 (n=%0d idx=%0d)",
                   it, state_mon, retry_cnt, lock_pwr, lock_tune, ST_BACKOFF, n, tidx);
          failures++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overflow();
    test_bad_index();
    test_timeout();
    test_loss();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
